fcvt_s_w_seq: RTL and testbench

//   Multi-cycle integer-to-single-precision converter (FCVT.S.W / FCVT.S.WU) for the FP unit.

---
 rtl/fcvt_s_w_seq.sv | 146 ++++++++++++++
 tb/tb_fcvt_s_w_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fcvt_s_w_seq.sv
// fcvt_s_w_seq: multi-cycle int32/uint32 to binary32 converter (FCVT.S.W / FCVT.S.WU)
//   clk          in   clock, rising edge
//   resetn       in   asynchronous active-low reset
//   start        in   request, sampled only in IDLE
//   rs1          in   32-bit integer operand, captured with start
//   is_unsigned  in   1 = FCVT.S.WU, 0 = FCVT.S.W, captured with start
//   rm           in   rounding mode (RNE/RTZ/RDN/RUP/RMM, 101-111 as RNE), captured with start
//   busy         out  high whenever not IDLE
//   done         out  one-cycle pulse, out/nx valid from this cycle
//   out          out  binary32 result, held until the next done
//   nx           out  inexact flag, held with out
module fcvt_s_w_seq #(
    parameter int BIAS = 127
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] rs1,
    input  logic        is_unsigned,
    input  logic [2:0]  rm,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        nx
);
    typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [4:0]  lz_q, lz_d;
    logic        sign_q, sign_d;
    logic        uns_q, uns_d;
    logic [2:0]  rm_q, rm_d;
    logic [31:0] out_q, out_d;
    logic        nx_q, nx_d;
    // In ABS, mag_q still holds the raw operand; the two's-complement
    // negate wraps 0x80000000 onto itself, which is the correct magnitude.
    logic        sign_abs;
    logic [31:0] mag_abs;
    logic [22:0] man, man_fin;
    logic        g, s, inexact, rnd_up;
    logic [23:0] man_inc;
    logic [7:0]  exp_base, exp_fin;
    always_comb begin
        sign_abs = ~uns_q & mag_q[31];
        mag_abs  = sign_abs ? -mag_q : mag_q;
    end
    // Rounding datapath, meaningful only in ROUND when mag_q[31] is set
    always_comb begin
        man     = mag_q[30:8];
        g       = mag_q[7];
        s       = |mag_q[6:0];
        inexact = g | s;
        case (rm_q)
            3'b001:  rnd_up = 1'b0;
            3'b010:  rnd_up = inexact & sign_q;
            3'b011:  rnd_up = inexact & ~sign_q;
            3'b100:  rnd_up = g;
            default: rnd_up = g & (s | man[0]);
        endcase
        man_inc  = {1'b0, man} + 24'd1;
        exp_base = 8'(BIAS + 31) - {3'b0, lz_q};
        // A mantissa carry leaves man_inc[22:0] at zero, so only the exponent needs bumping
        man_fin  = rnd_up ? man_inc[22:0] : man;
        exp_fin  = exp_base + {7'b0, rnd_up & man_inc[23]};
    end
    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            mag_q   <= '0;
            lz_q    <= '0;
            sign_q  <= 1'b0;
            uns_q   <= 1'b0;
            rm_q    <= '0;
            out_q   <= '0;
            nx_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            lz_q    <= lz_d;
            sign_q  <= sign_d;
            uns_q   <= uns_d;
            rm_q    <= rm_d;
            out_q   <= out_d;
            nx_q    <= nx_d;
        end
    end
    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? ABS : IDLE;
            ABS:     state_d = (mag_abs == 32'd0) ? DONE : NORM;
            NORM:    state_d = mag_q[31] ? ROUND : NORM;
            ROUND:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Datapath next values
    always_comb begin
        mag_d  = mag_q;
        lz_d   = lz_q;
        sign_d = sign_q;
        uns_d  = uns_q;
        rm_d   = rm_q;
        out_d  = out_q;
        nx_d   = nx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mag_d = rs1;
                    uns_d = is_unsigned;
                    rm_d  = rm;
                end
            end
            ABS: begin
                sign_d = sign_abs;
                mag_d  = mag_abs;
                lz_d   = '0;
                if (mag_abs == 32'd0) begin
                    out_d = '0;
                    nx_d  = 1'b0;
                end
            end
            NORM: begin
                if (!mag_q[31]) begin
                    mag_d = mag_q << 1;
                    lz_d  = lz_q + 5'd1;
                end
            end
            ROUND: begin
                out_d = {sign_q, exp_fin, man_fin};
                nx_d  = inexact;
            end
            default: ;
        endcase
    end
    // Outputs
    always_comb begin
        busy = state_q != IDLE;
        done = state_q == DONE;
        out  = out_q;
        nx   = nx_q;
    end
endmodule

// File: tb/tb_fcvt_s_w_seq.sv
// tb_fcvt_s_w_seq: scoreboard bench for fcvt_s_w_seq with directed vectors
module tb_fcvt_s_w_seq;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] rs1 = '0;
    logic        is_unsigned = 1'b0;
    logic [2:0]  rm = '0;
    logic        busy, done, nx;
    logic [31:0] out;

    fcvt_s_w_seq dut (
        .clk(clk), .resetn(resetn), .start(start), .rs1(rs1),
        .is_unsigned(is_unsigned), .rm(rm), .busy(busy), .done(done),
        .out(out), .nx(nx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] o;
        logic        x;
        int          lat;
        int          base;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, x, cyc);
        end
    endtask

    // Monitor: every done pulse pops one expected result
    always @(negedge clk) begin
        if (resetn && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("out", out, e.o);
                chk("nx", {31'b0, nx}, {31'b0, e.x});
                chk("latency", cyc - e.base, e.lat);
            end
        end
    end

    task automatic wait_idle(input string n);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy still 1 expected 0", n);
        end
    endtask

    task automatic run(input [31:0] a, input logic u, input [2:0] m,
                       input [31:0] eo, input logic ex, input int lat);
        exp_t t;
        @(negedge clk);
        rs1 = a;
        is_unsigned = u;
        rm = m;
        start = 1'b1;
        t.o = eo; t.x = ex; t.lat = lat; t.base = cyc;
        q.push_back(t);
        @(negedge clk);
        start = 1'b0;
        rs1 = $urandom;
        is_unsigned = ~u;
        rm = 3'($urandom);
        wait_idle("run");
        chk("drained", q.size(), 0);
    endtask

    initial begin
        exp_t t;
        int c, nd;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_out", out, 0);
        chk("rst_nx", {31'b0, nx}, 0);
        resetn = 1'b1;

        run(32'h0000_0001, 0, 3'b000, 32'h3F80_0000, 0, 35);
        run(32'hFFFF_FFFF, 0, 3'b000, 32'hBF80_0000, 0, 35);
        run(32'h0000_0000, 0, 3'b000, 32'h0000_0000, 0, 2);
        run(32'h7FFF_FFFF, 0, 3'b000, 32'h4F00_0000, 1, 5);
        run(32'h7FFF_FFFF, 0, 3'b001, 32'h4EFF_FFFF, 1, 5);
        run(32'h7FFF_FFFF, 0, 3'b111, 32'h4F00_0000, 1, 5);
        run(32'h8000_0000, 0, 3'b000, 32'hCF00_0000, 0, 4);
        run(32'h8000_0000, 1, 3'b000, 32'h4F00_0000, 0, 4);
        run(32'hFFFF_FFFF, 1, 3'b000, 32'h4F80_0000, 1, 4);
        run(32'h0100_0001, 0, 3'b000, 32'h4B80_0000, 1, 11);
        run(32'h0100_0001, 0, 3'b011, 32'h4B80_0001, 1, 11);
        run(32'h0100_0001, 0, 3'b100, 32'h4B80_0001, 1, 11);
        run(32'h0100_0001, 0, 3'b001, 32'h4B80_0000, 1, 11);
        run(32'hFEFF_FFFF, 0, 3'b010, 32'hCB80_0001, 1, 11);
        run(32'hFEFF_FFFF, 0, 3'b011, 32'hCB80_0000, 1, 11);
        chk("hold_out", out, 32'hCB80_0000);

        // Second start while busy must be ignored
        @(negedge clk);
        c = cyc;
        rs1 = 32'h0000_0001; is_unsigned = 0; rm = 3'b000; start = 1'b1;
        t.o = 32'h3F80_0000; t.x = 0; t.lat = 35; t.base = c;
        q.push_back(t);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rs1 = 32'h7FFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ignore");
        repeat (5) @(negedge clk);
        chk("ignore_drained", q.size(), 0);

        // Start held: a new conversion begins in the cycle after each done
        @(negedge clk);
        c = cyc;
        t.o = 32'h3F80_0000; t.x = 0; t.lat = 35; t.base = c;
        q.push_back(t);
        t.o = 32'h0000_0000; t.x = 0; t.lat = 2; t.base = c + 36;
        q.push_back(t);
        rs1 = 32'h0000_0001; is_unsigned = 0; rm = 3'b000; start = 1'b1;
        @(negedge clk);
        rs1 = 32'h0000_0000;
        nd = 0;
        for (int i = 0; i < 100 && nd < 2; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        start = 1'b0;
        if (nd < 2) begin
            checks++;
            errors++;
            $display("FAIL held_timeout: got %0d dones expected 2", nd);
        end
        wait_idle("held");
        repeat (3) @(negedge clk);
        chk("held_drained", q.size(), 0);

        // Reset during NORM discards the conversion
        run(32'h0000_0003, 0, 3'b000, 32'h4040_0000, 0, 34);
        @(negedge clk);
        c = cyc;
        rs1 = 32'h0000_0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 10) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_done", {31'b0, done}, 0);
        chk("mid_rst_out", out, 0);
        chk("mid_rst_nx", {31'b0, nx}, 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (45) @(negedge clk);
        chk("post_rst_busy", {31'b0, busy}, 0);
        chk("post_rst_out", out, 0);
        run(32'h7FFF_FFFF, 0, 3'b001, 32'h4EFF_FFFF, 1, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
